instr_fetch_unit: RTL and testbench

- Producer end of the instruction-word interface: fetches 32-bit RISC-V instruction words from instruction memory and presents them, with their PC, to the control-unit decoder's instruction input.
- Owns the PC register, a request/response handshake to IMEM, and a small in-order instruction queue.
- Accepts a redirect (resolved jal/jalr/branch target) that flushes queued and in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order requests to IMEM and
// buffers returned words in a small queue for the decoder. A redirect
// flushes the queue and discards any responses still in flight.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0]      NOP      = 32'h0000_0013;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   QDEPTH_W = (CNT_W + 1)'(QDEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           state_reg;
    logic [31:0]      pc_reg;
    logic [CNT_W-1:0] outstanding_reg;
    logic [CNT_W-1:0] qcount_reg;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] qcount_next;
    logic [PTR_W-1:0] q_head_reg;
    logic [PTR_W-1:0] q_tail_reg;
    logic [PTR_W-1:0] pf_head_reg;
    logic [PTR_W-1:0] pf_tail_reg;
    logic             misalign_err_reg;

    // Instruction queue (word + its PC) and the PC FIFO of outstanding requests
    logic [31:0] q_data_mem [QDEPTH];
    logic [31:0] q_pc_mem   [QDEPTH];
    logic [31:0] pf_mem     [QDEPTH];

    logic [CNT_W:0] credit_used;
    logic           run_st;
    logic           req_fire;
    logic           rsp_take;
    logic           push;
    logic           pop;

    assign run_st      = (state_reg == ST_RUN);
    // Requests in flight plus queued words may never exceed the queue size,
    // so every response is guaranteed a free queue slot.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, qcount_reg};

    assign imem_req_valid = rst_n && !redirect_valid && run_st && (credit_used < QDEPTH_W);
    assign imem_addr      = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign rsp_take = imem_rsp_valid && (outstanding_reg != '0);
    assign push     = rsp_take && run_st && !redirect_valid;

    assign instr_valid = run_st && (qcount_reg != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    assign instr_out    = (qcount_reg != '0) ? q_data_mem[q_head_reg] : NOP;
    assign instr_pc     = (qcount_reg != '0) ? q_pc_mem[q_head_reg]   : 32'h0000_0000;
    assign misalign_err = misalign_err_reg;

    // Next values of the outstanding-request and queue-occupancy counters
    always_comb begin
        outstanding_next = outstanding_reg;
        case ({req_fire, rsp_take})
            2'b10:   outstanding_next = outstanding_reg + CNT_ONE;
            2'b01:   outstanding_next = outstanding_reg - CNT_ONE;
            default: outstanding_next = outstanding_reg;
        endcase

        qcount_next = qcount_reg;
        case ({push, pop})
            2'b10:   qcount_next = qcount_reg + CNT_ONE;
            2'b01:   qcount_next = qcount_reg - CNT_ONE;
            default: qcount_next = qcount_reg;
        endcase
    end

    // Control state: FSM, PC, counters, queue and PC-FIFO pointers, error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= ST_RUN;
            pc_reg           <= RESET_PC;
            outstanding_reg  <= '0;
            qcount_reg       <= '0;
            q_head_reg       <= '0;
            q_tail_reg       <= '0;
            pf_head_reg      <= '0;
            pf_tail_reg      <= '0;
            misalign_err_reg <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_next;

            // The PC FIFO advances on every accepted request and every
            // response, dropped or not, so it stays aligned with IMEM order.
            if (req_fire) begin
                pc_reg      <= pc_reg + 32'd4;
                pf_tail_reg <= pf_tail_reg + PTR_ONE;
            end
            if (rsp_take) begin
                pf_head_reg <= pf_head_reg + PTR_ONE;
            end

            if (redirect_valid) begin
                // Redirect wins over push, pop and request
                pc_reg           <= redirect_pc & 32'hFFFF_FFFC;
                misalign_err_reg <= redirect_pc[1];
                qcount_reg       <= '0;
                q_head_reg       <= q_tail_reg;
                state_reg        <= (outstanding_next != '0) ? ST_DRAIN : ST_RUN;
            end else begin
                qcount_reg <= qcount_next;
                if (push) begin
                    q_tail_reg <= q_tail_reg + PTR_ONE;
                end
                if (pop) begin
                    q_head_reg <= q_head_reg + PTR_ONE;
                end
                if (state_reg == ST_DRAIN && outstanding_next == '0) begin
                    state_reg <= ST_RUN;
                end
            end
        end
    end

    // Storage writes: request PCs on issue, {word, pc} on an accepted response
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pf_mem[pf_tail_reg] <= pc_reg;
        end
        if (push) begin
            q_data_mem[q_tail_reg] <= imem_rsp_data;
            q_pc_mem[q_tail_reg]   <= pf_mem[pf_head_reg];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle-latency IMEM model and
// a scoreboard of expected {word, pc} pairs delivered to the decoder.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    // Bench-side model state
    logic [31:0] pending[$];      // addresses accepted by IMEM, not yet answered
    logic [63:0] exp_q[$];        // expected {word, pc} in decoder order
    int          drop_count = 0;  // responses still to be discarded after a redirect
    logic [31:0] exp_pc;
    logic        exp_mis;
    bit          rsp_hold = 1'b0;
    int          req_count = 0;

    instr_fetch_unit #(
        .RESET_PC(RESET_PC),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, update the model from
    // what crosses the interfaces at this edge, then drive the next response.
    task automatic tick();
        logic [31:0] front;
        logic        req_exp;
        int          used;
        #1;
        used = pending.size() + exp_q.size();
        if (rst_n) begin
            req_exp = !redirect_valid && (drop_count == 0) && (used < QDEPTH);
            check("req_valid", imem_req_valid, req_exp);
            if (imem_req_valid) check("imem_addr", imem_addr, exp_pc);
            check("misalign", misalign_err, exp_mis);
            check("instr_valid", instr_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("instr_out", instr_out, exp_q[0][63:32]);
                check("instr_pc", instr_pc, exp_q[0][31:0]);
            end else begin
                check("empty_nop", instr_out, NOP);
                check("empty_pc", instr_pc, 32'h0);
            end
            check("credit_inv",
                  ({1'b0, dut.outstanding_reg} + {1'b0, dut.qcount_reg}) <= QDEPTH, 1'b1);

            if (exp_q.size() != 0 && instr_ready && !redirect_valid) begin
                void'(exp_q.pop_front());
            end
            if (imem_rsp_valid && pending.size() != 0) begin
                front = pending.pop_front();
                if (redirect_valid) begin
                    // dropped by the redirect
                end else if (drop_count > 0) begin
                    drop_count--;
                end else begin
                    exp_q.push_back({mem_word(front), front});
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                drop_count = pending.size();
                exp_pc     = {redirect_pc[31:2], 2'b00};
                exp_mis    = redirect_pc[1];
            end else if (imem_req_valid && imem_req_ready) begin
                pending.push_back(imem_addr);
                exp_pc = exp_pc + 32'd4;
                req_count++;
            end
        end else begin
            check("req_in_reset", imem_req_valid, 1'b0);
            pending.delete();
            exp_q.delete();
            drop_count = 0;
            exp_pc     = RESET_PC;
            exp_mis    = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (!rsp_hold && pending.size() != 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pending[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_pc         = RESET_PC;
        exp_mis        = 1'b0;
        @(negedge clk);

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_valid", instr_valid, 1'b0);
        check("rst_nop", instr_out, NOP);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_mis", misalign_err, 1'b0);

        // Streaming: first word at cycle 2, next on the following cycle
        tick();
        tick();
        #1;
        check("c2_valid", instr_valid, 1'b1);
        check("c2_out", instr_out, mem_word(32'h0));
        check("c2_pc", instr_pc, 32'h0);
        tick();
        #1;
        check("c3_valid", instr_valid, 1'b1);
        check("c3_out", instr_out, mem_word(32'h4));
        check("c3_pc", instr_pc, 32'h4);
        repeat (8) tick();

        // Decoder stalled from reset: exactly QDEPTH requests, head held
        rst_n = 1'b0;
        tick();
        rst_n       = 1'b1;
        instr_ready = 1'b0;
        req_count   = 0;
        repeat (10) tick();
        #1;
        check("stall_reqs", req_count, QDEPTH);
        check("stall_head_out", instr_out, mem_word(32'h0));
        check("stall_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        repeat (6) tick();

        // Redirect with two requests outstanding -> drain
        rsp_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (pending.size() == 2 && exp_q.size() == 0 && !imem_rsp_valid) break;
            tick();
        end
        check("drain_setup", pending.size() == 2 && !imem_rsp_valid, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("drain_ivalid", instr_valid, 1'b0);
        check("drain_req", imem_req_valid, 1'b0);
        rsp_hold = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) break;
            tick();
        end
        #1;
        check("redir_first_valid", instr_valid, 1'b1);
        check("redir_first_pc", instr_pc, 32'h0000_0100);
        repeat (6) tick();

        // Redirect coinciding with a response and a pop
        for (int i = 0; i < 20; i++) begin
            if (imem_rsp_valid && instr_valid) break;
            tick();
        end
        check("rsr_setup", imem_rsp_valid && instr_valid, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rsr_empty", instr_valid, 1'b0);
        check("rsr_addr", imem_addr, 32'h0000_0200);
        repeat (6) tick();

        // Misaligned redirect target sets the sticky flag, next one clears it
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0206;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("mis_addr", imem_addr, 32'h0000_0204);
        check("mis_flag", misalign_err, 1'b1);
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("mis_clear", misalign_err, 1'b0);
        check("mis_addr2", imem_addr, 32'h0000_0300);
        repeat (4) tick();

        // Reset mid-stream with a full queue
        instr_ready = 1'b0;
        repeat (6) tick();
        #1;
        check("full_valid", instr_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mrst_valid", instr_valid, 1'b0);
        check("mrst_nop", instr_out, NOP);
        check("mrst_addr", imem_addr, RESET_PC);
        check("mrst_outst", dut.outstanding_reg, 32'h0);
        instr_ready = 1'b1;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
